axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

AXI3 slave responder that fronts an on-chip single-port word SRAM and answers the read/write channels driven by the CPU-side SRAM-to-AXI bridge. Serves single-beat and INCR burst reads (up to 256 beats, rid echoed) and single-beat byte-masked writes (bid echoed). Sits at the far end of the bridge in simulation and FPGA top levels as the program/data memory.

## Interface
- RAM_AW, 14, SRAM word-address width (depth = 2^RAM_AW words of 32 bits)
- aclk  in  1  clock
- areset  in  1  reset; asynchronous, active-high
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read request; arburst ignored, always INCR
- arvalid  in  1; arready  out  1
- rid/rdata/rresp/rlast  out  4/32/2/1  read response
- rvalid  out  1; rready  in  1
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write request; awlen must be 0
- awvalid  in  1; awready  out  1
- wid/wdata/wstrb/wlast  in  4/32/4/1  write data; wid, wlast ignored
- wvalid  in  1; wready  out  1
- bid/bresp  out  4/2  write response
- bvalid  out  1; bready  in  1

## Operation
- FSM states: IDLE, RD_REQ, RD_DATA, WR_RESP.
- Write holding regs: AW hold (id, word addr), W hold (data, strb), each with a full flag. awready = !aw_full && state!=WR_RESP; wready = !w_full && state!=WR_RESP. AW and W accepted independently, any order, same cycle allowed.
- IDLE: if aw_full && w_full -> SRAM write with byte enables = wstrb, bid <= aw id, -> WR_RESP. Else arready=1; on arvalid: latch rid, word addr araddr[RAM_AW+1:2], beat counter = arlen -> RD_REQ.
- Write priority only when both holds full at IDLE; an AR presented while a hold is half-filled wins.
- RD_REQ: issue SRAM read of current word addr -> RD_DATA.
- RD_DATA: rvalid=1, rdata = registered SRAM output (held stable while !rready), rlast = (counter==0). On rready: if last -> IDLE, else counter-1, addr+1 -> RD_REQ.
- WR_RESP: bvalid=1; on bready clear both holds -> IDLE.
- Address wrap: addr bits above RAM_AW+1 ignored; burst increment wraps modulo 2^RAM_AW.
- arsize<2: full word returned, requester extracts bytes. awsize ignored; wstrb governs bytes.
- rresp, bresp always 2'b00 (OKAY).
- Reset (any time, mid-burst included): state IDLE, holds empty, rvalid/bvalid/rlast 0, rid/bid/rdata 0; ready outputs forced 0 while areset high. SRAM contents not cleared.

## Timing
- AR handshake at cycle T -> first rvalid at T+2; each following beat rvalid 2 cycles after previous R handshake (rready tied high gives one beat per 2 cycles).
- AW and W both handshaken at T -> SRAM write at T+1 -> bvalid from T+2 until bready.
- Write data visible to a read whose AR handshakes at or after the B handshake.
- One outstanding transaction at a time; no read/write overlap in the SRAM.

## Configuration
- AXI_SLV_STALL_EN defined: 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle; when lfsr[0]==1, arready/awready/wready forced 0 and RD_REQ holds one extra cycle without issuing the read. Used to stress the bridge's handshakes.
- Undefined: no LFSR, timing exactly as in Timing.

## Structure
- Package axi_slv_pkg: FSM state enum, RESP_OKAY constant, LFSR seed and tap constants, default RAM_AW.
- Sub-module axi_slv_sram: synchronous single-port 32-bit SRAM, 4 byte write enables, 1-cycle registered read.

## Test plan
- Reset, then single read arid=1 araddr=0x1c008000 arlen=0 of preloaded 0xDEADBEEF -> rvalid at T+2, rdata=0xDEADBEEF, rid=1, rlast=1, rresp=0.
- Burst read arid=0 arlen=3 at 0x100 (words 0x11,0x22,0x33,0x44) with rready=1 -> four beats 2 cycles apart, rlast only on 0x44.
- Write awid=1 addr 0x200 wdata=0xAABBCCDD wstrb=4'b0101 over word 0x0 (W one cycle before AW) -> bvalid, bid=1; readback 0x00BB00DD.
- rready low 5 cycles on beat 2 of a burst -> rvalid, rdata, rlast stable; burst resumes on rready.
- AR at top word 2^RAM_AW-1 with arlen=1 -> second beat returns word 0.
- areset asserted mid-burst -> rvalid and arready drop immediately; after release a new single read completes normally.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// Shared definitions for the AXI3 SRAM slave: FSM state encoding, response
// code, stall LFSR constants and the default SRAM word-address width.
package axi_slv_pkg;

  localparam int          RAM_AW_DEF = 14;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  // Fibonacci LFSR, taps 16,14,13,11 mapped to bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR_RESP = 2'd3
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axi_slv_sram.sv
// Synchronous single-port 32-bit word SRAM with per-byte write enables and a
// one-cycle registered read port. Contents are never cleared; only the read
// register returns to zero on reset so rdata is quiet after reset.
module axi_slv_sram
  import axi_slv_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<RAM_AW)-1];

  // Byte-masked write of the addressed word
  always_ff @(posedge aclk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read; output holds until the next read is issued
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                   rdata <= '0;
    else if (en && (we == 4'b0))  rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave fronting a single-port word SRAM. Serves INCR read bursts of up
// to 256 beats and single-beat byte-masked writes, one transaction at a time.
// Optional macro AXI_SLV_STALL_EN adds an LFSR that randomly withholds the
// ready signals and delays the SRAM read issue to stress the requester.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF
) (
  input  logic        aclk,
  input  logic        areset,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  state_e            state, state_nxt;
  logic              stall;
  logic [RAM_AW-1:0] rd_addr;
  logic [7:0]        rd_cnt;
  logic              aw_full, w_full;
  logic [3:0]        aw_id;
  logic [RAM_AW-1:0] aw_addr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic              wr_go;
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [RAM_AW-1:0] sram_addr;
  logic              ar_hs, aw_hs, w_hs, b_hs;

  // Burst type, sizes, write length/id/last and out-of-range address bits
  // have no effect on this memory
  logic unused_inputs;
  assign unused_inputs = ^{araddr[31:RAM_AW+2], araddr[1:0], arsize, arburst,
                           awaddr[31:RAM_AW+2], awaddr[1:0], awlen, awsize,
                           awburst, wid, wlast};

`ifdef AXI_SLV_STALL_EN
  logic [15:0] lfsr;

  // Free-running stall pattern generator
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_next(lfsr);
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  // A complete write waiting at IDLE takes priority over a new read request
  assign wr_go = (state == ST_IDLE) && aw_full && w_full;

  assign rresp = RESP_OKAY;
  assign bresp = RESP_OKAY;

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (wr_go)      state_nxt = ST_WR_RESP;
        else if (ar_hs) state_nxt = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        if (!stall) state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (rready) state_nxt = (rd_cnt == 8'd0) ? ST_IDLE : ST_RD_REQ;
      end
      ST_WR_RESP: begin
        if (bready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output and SRAM control decode; ready outputs are held low during reset
  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    bvalid  = 1'b0;
    sram_en = 1'b0;
    sram_we = 4'b0;
    case (state)
      ST_IDLE: begin
        if (wr_go) begin
          sram_en = 1'b1;
          sram_we = w_strb;
        end else begin
          arready = !stall && !areset;
        end
      end
      ST_RD_REQ:  sram_en = !stall;
      ST_RD_DATA: begin
        rvalid = 1'b1;
        rlast  = (rd_cnt == 8'd0);
      end
      ST_WR_RESP: bvalid = 1'b1;
      default: ;
    endcase
    awready = !aw_full && (state != ST_WR_RESP) && !stall && !areset;
    wready  = !w_full  && (state != ST_WR_RESP) && !stall && !areset;
  end

  assign sram_addr = wr_go ? aw_addr : rd_addr;

  // Read burst tracking: capture on AR, advance on each non-final R handshake
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rid     <= '0;
      rd_addr <= '0;
      rd_cnt  <= '0;
    end else if (ar_hs) begin
      rid     <= arid;
      rd_addr <= araddr[RAM_AW+1:2];
      rd_cnt  <= arlen;
    end else if ((state == ST_RD_DATA) && rready && (rd_cnt != 8'd0)) begin
      rd_cnt  <= rd_cnt - 8'd1;
      rd_addr <= rd_addr + {{(RAM_AW-1){1'b0}}, 1'b1};
    end
  end

  // Write hold full flags: set on their own handshake, cleared on B handshake
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else if (b_hs) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_hs) aw_full <= 1'b1;
      if (w_hs)  w_full  <= 1'b1;
    end
  end

  // Write hold payloads, only meaningful while the matching flag is set
  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      aw_id   <= awid;
      aw_addr <= awaddr[RAM_AW+1:2];
    end
    if (w_hs) begin
      w_data <= wdata;
      w_strb <= wstrb;
    end
  end

  // Write response id, taken from the AW hold when the SRAM write fires
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)     bid <= '0;
    else if (wr_go) bid <= aw_id;
  end

  axi_slv_sram #(
    .RAM_AW (RAM_AW)
  ) u_sram (
    .aclk   (aclk),
    .areset (areset),
    .en     (sram_en),
    .we     (sram_we),
    .addr   (sram_addr),
    .wdata  (w_data),
    .rdata  (rdata)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave: reset values, single and
// burst reads, masked writes, R back-pressure, address wrap and mid-burst reset.
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_words [0:7];
  int          stall_beat;

  always #5 aclk = ~aclk;

  axi_sram_slave dut (
    .aclk    (aclk),
    .areset  (areset),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wid     (wid),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Single-beat write; W is presented w_lead cycles before AW
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_hs, w_hs;
    int n;
    awid = id; awaddr = addr; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1;
    wid = id; wdata = data; wstrb = strb; wlast = 1'b1;
    wvalid  = 1'b1;
    awvalid = (w_lead == 0);
    for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge aclk);
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
      if (!aw_done && (i + 1 >= w_lead)) awvalid = 1'b1;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("aw_w_accept", {30'd0, aw_done, w_done}, 32'd3);
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    check("bvalid", {31'd0, bvalid}, 32'd1);
`ifndef AXI_SLV_STALL_EN
    check("b_latency", n, 32'd1);
`endif
    check("bid", {28'd0, bid}, {28'd0, id});
    check("bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_drop", {31'd0, bvalid}, 32'd0);
  endtask

  // Read burst checked against exp_words; beat stall_beat gets 5 cycles of back-pressure
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit hs = 1'b0;
    int n;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = 2'd1;
    arvalid = 1'b1;
    rready  = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = arready;
      @(negedge aclk);
    end
    arvalid = 1'b0;
    check("ar_accept", {31'd0, hs}, 32'd1);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge aclk); n++; end
      check("rvalid", {31'd0, rvalid}, 32'd1);
`ifndef AXI_SLV_STALL_EN
      check("r_latency", n, 32'd1);
`endif
      check("rdata", rdata, exp_words[b]);
      check("rid", {28'd0, rid}, {28'd0, id});
      check("rresp", {30'd0, rresp}, 32'd0);
      check("rlast", {31'd0, rlast}, {31'd0, (b == int'(len))});
      if (b == stall_beat) begin
        rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge aclk);
          check("hold_rvalid", {31'd0, rvalid}, 32'd1);
          check("hold_rdata", rdata, exp_words[b]);
          check("hold_rlast", {31'd0, rlast}, {31'd0, (b == int'(len))});
        end
        rready = 1'b1;
      end
      @(negedge aclk);
    end
    rready = 1'b0;
  endtask

  initial begin
    int  n;
    bit  hs;
    areset  = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    stall_beat = -1;
    repeat (3) @(negedge aclk);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    areset = 1'b0;
    @(negedge aclk);
`ifndef AXI_SLV_STALL_EN
    check("idle_arready", {31'd0, arready}, 32'd1);
    check("idle_awready", {31'd0, awready}, 32'd1);
`endif
    check("idle_rid",   {28'd0, rid}, 32'd0);
    check("idle_bid",   {28'd0, bid}, 32'd0);
    check("idle_rdata", rdata, 32'd0);
    check("idle_rlast", {31'd0, rlast}, 32'd0);

    // preload memory through the write channel
    axi_write(4'd0, 32'h0000_8000, 32'hDEAD_BEEF, 4'hF, 0);
    axi_write(4'd0, 32'h0000_0100, 32'h0000_0011, 4'hF, 0);
    axi_write(4'd0, 32'h0000_0104, 32'h0000_0022, 4'hF, 0);
    axi_write(4'd0, 32'h0000_0108, 32'h0000_0033, 4'hF, 0);
    axi_write(4'd0, 32'h0000_010C, 32'h0000_0044, 4'hF, 0);
    axi_write(4'd0, 32'h0000_FFFC, 32'h7777_1234, 4'hF, 0);
    axi_write(4'd0, 32'h0000_0000, 32'h5A5A_0000, 4'hF, 0);
    axi_write(4'd0, 32'h0000_0200, 32'h0000_0000, 4'hF, 0);

    // single read through an aliased upper address
    exp_words[0] = 32'hDEAD_BEEF;
    axi_read(4'd1, 32'h1C00_8000, 8'd0);

    // four-beat burst
    exp_words[0] = 32'h11; exp_words[1] = 32'h22;
    exp_words[2] = 32'h33; exp_words[3] = 32'h44;
    axi_read(4'd0, 32'h0000_0100, 8'd3);

    // masked writes, W leading AW, then aligned
    axi_write(4'd1, 32'h0000_0200, 32'hAABB_CCDD, 4'b0101, 1);
    exp_words[0] = 32'h00BB_00DD;
    axi_read(4'd2, 32'h0000_0200, 8'd0);
    axi_write(4'd3, 32'h0000_0200, 32'h1122_3344, 4'b1010, 0);
    exp_words[0] = 32'h11BB_33DD;
    axi_read(4'd3, 32'h0000_0200, 8'd0);

    // back-pressure on beat 2 of a burst
    exp_words[0] = 32'h11; exp_words[1] = 32'h22;
    exp_words[2] = 32'h33; exp_words[3] = 32'h44;
    stall_beat = 1;
    axi_read(4'd5, 32'h0000_0100, 8'd3);
    stall_beat = -1;

    // wrap from the top word back to word 0
    exp_words[0] = 32'h7777_1234; exp_words[1] = 32'h5A5A_0000;
    axi_read(4'd6, 32'h0000_FFFC, 8'd1);

    // reset while a burst beat is waiting
    arid = 4'd7; araddr = 32'h0000_0100; arlen = 8'd3; arvalid = 1'b1; rready = 1'b0;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = arready;
      @(negedge aclk);
    end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge aclk); n++; end
    check("mb_rvalid_pre", {31'd0, rvalid}, 32'd1);
    check("mb_rdata_pre", rdata, 32'h11);
    #2 areset = 1'b1;
    #1;
    check("mb_rvalid", {31'd0, rvalid}, 32'd0);
    check("mb_arready", {31'd0, arready}, 32'd0);
    check("mb_awready", {31'd0, awready}, 32'd0);
    check("mb_rlast", {31'd0, rlast}, 32'd0);
    check("mb_rdata", rdata, 32'd0);
    check("mb_rid", {28'd0, rid}, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
`ifndef AXI_SLV_STALL_EN
    check("mb_arready_post", {31'd0, arready}, 32'd1);
`endif
    exp_words[0] = 32'hDEAD_BEEF;
    axi_read(4'd8, 32'h0000_8000, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
